// File: rtl/sobel_pkg.sv
// sobel_pkg: shared defaults and control state type for the Sobel line buffer
package sobel_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int LINE_LEN_DEF = 32;
  typedef enum logic {FILL, RUN} state_t;
endpackage

// File: rtl/sobel_line_delay.sv
// sobel_line_delay: one circular line of LINE_LEN pixels, read-before-write at an external pointer
module sobel_line_delay
  import sobel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LINE_LEN = LINE_LEN_DEF,
  localparam int PW = $clog2(LINE_LEN)
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic [PW-1:0]     i_ptr,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);
  logic [DATA_W-1:0] r_mem [LINE_LEN];
  // storage is deliberately unreset; the top masks entries not yet written
  assign o_data = r_mem[i_ptr];
  always_ff @(posedge i_clk)
    if (i_en) r_mem[i_ptr] <= i_data;
endmodule

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: cascaded line delays presenting a vertical pixel window with fill tracking
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LINE_LEN = LINE_LEN_DEF,
  parameter int NUM_LINES = 2,
  localparam int PW = $clog2(LINE_LEN),
  localparam int FW = $clog2(NUM_LINES*LINE_LEN+1)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            Enable,
  input  logic [DATA_W-1:0]               DataIn,
  output logic [(NUM_LINES+1)*DATA_W-1:0] TapOut,
  output logic                            Valid,
  output logic [PW-1:0]                   Col,
  output logic                            LineEnd
);
  localparam logic [PW-1:0] PMAX = PW'(LINE_LEN-1);
  localparam logic [FW-1:0] FMAX = FW'(NUM_LINES*LINE_LEN);
  logic [PW-1:0] r_ptr;
  logic [FW-1:0] r_fill;
  state_t r_state;
  logic [(NUM_LINES+1)*DATA_W-1:0] r_tap;
  logic r_valid;
  logic [PW-1:0] r_col;
  logic r_lineend;
  logic [DATA_W-1:0] w_tap [NUM_LINES+1];
  logic [(NUM_LINES+1)*DATA_W-1:0] w_tap_nxt;
  assign w_tap[0] = DataIn;
  for (genvar i = 1; i <= NUM_LINES; i++) begin : g_line
    sobel_line_delay #(.DATA_W(DATA_W), .LINE_LEN(LINE_LEN)) u_line (
      .i_clk (CLK),
      .i_en  (Enable),
      .i_ptr (r_ptr),
      .i_data(w_tap[i-1]),
      .o_data(w_tap[i])
    );
  end
  // tap k only carries real data once more than k lines have been fed
  always_comb begin
    w_tap_nxt = '0;
    for (int k = 0; k <= NUM_LINES; k++)
      w_tap_nxt[k*DATA_W +: DATA_W] = (r_fill >= FW'(k*LINE_LEN)) ? w_tap[k] : '0;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_ptr     <= '0;
      r_fill    <= '0;
      r_state   <= FILL;
      r_tap     <= '0;
      r_valid   <= 1'b0;
      r_col     <= '0;
      r_lineend <= 1'b0;
    end else if (Enable) begin
      r_tap     <= w_tap_nxt;
      r_ptr     <= (r_ptr == PMAX) ? '0 : r_ptr + 1'b1;
      r_col     <= r_ptr;
      r_lineend <= (r_ptr == PMAX);
      if (r_fill != FMAX) r_fill <= r_fill + 1'b1;
      if (r_state == FILL && r_fill == FMAX) begin
        r_state <= RUN;
        r_valid <= 1'b1;
      end
    end
  assign TapOut  = r_tap;
  assign Valid   = r_valid;
  assign Col     = r_col;
  assign LineEnd = r_lineend;
endmodule

// File: tb/tb_sobel_line_buffer.sv
// tb_sobel_line_buffer: directed and randomized checks of two line buffer configurations against a sample-history model
module tb_sobel_line_buffer;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;
  logic ena = 1'b0, enb = 1'b0;
  logic [7:0] da = '0, db = '0;
  logic [23:0] tap_a;
  logic [31:0] tap_b;
  logic va, vb, le_a, le_b;
  logic [1:0] col_a;
  logic [2:0] col_b;
  logic [7:0] ha[$];
  logic [7:0] hb[$];
  int n_checks = 0;
  int n_pass = 0;

  sobel_line_buffer #(.DATA_W(8), .LINE_LEN(4), .NUM_LINES(2)) u_a (
    .CLK(CLK), .RST(RST), .Enable(ena), .DataIn(da),
    .TapOut(tap_a), .Valid(va), .Col(col_a), .LineEnd(le_a)
  );
  sobel_line_buffer #(.DATA_W(8), .LINE_LEN(5), .NUM_LINES(3)) u_b (
    .CLK(CLK), .RST(RST), .Enable(enb), .DataIn(db),
    .TapOut(tap_b), .Valid(vb), .Col(col_b), .LineEnd(le_b)
  );

  function automatic logic [23:0] ref_tap_a();
    logic [23:0] t = '0;
    for (int k = 0; k < 3; k++)
      if (ha.size() > k*4) t[k*8 +: 8] = ha[ha.size()-1-k*4];
    return t;
  endfunction
  function automatic logic [31:0] ref_tap_b();
    logic [31:0] t = '0;
    for (int k = 0; k < 4; k++)
      if (hb.size() > k*5) t[k*8 +: 8] = hb[hb.size()-1-k*5];
    return t;
  endfunction
  function automatic logic [1:0] ref_col_a();
    return (ha.size() == 0) ? 2'd0 : 2'((ha.size()-1) % 4);
  endfunction
  function automatic logic [2:0] ref_col_b();
    return (hb.size() == 0) ? 3'd0 : 3'((hb.size()-1) % 5);
  endfunction

  task automatic step(input logic ea_i, input logic [7:0] da_i, input logic eb_i, input logic [7:0] db_i);
    @(negedge CLK);
    ena = ea_i; da = da_i; enb = eb_i; db = db_i;
    @(posedge CLK);
    if (ea_i) ha.push_back(da_i);
    if (eb_i) hb.push_back(db_i);
    #1;
  endtask

  task automatic assert_rst();
    @(negedge CLK);
    ena = 1'b0; enb = 1'b0;
    #2 RST = 1'b1;
    ha.delete(); hb.delete();
    #1;
  endtask

  task automatic release_rst();
    @(negedge CLK);
    #2 RST = 1'b0;
  endtask

  task automatic test_reset();
    assert_rst();
    n_checks++; if (tap_a !== 24'h0) $display("FAIL reset_tap got %h want 000000", tap_a); else n_pass++;
    n_checks++; if (va !== 1'b0) $display("FAIL reset_valid got %b want 0", va); else n_pass++;
    n_checks++; if (col_a !== 2'd0) $display("FAIL reset_col got %0d want 0", col_a); else n_pass++;
    n_checks++; if (le_a !== 1'b0) $display("FAIL reset_lineend got %b want 0", le_a); else n_pass++;
    n_checks++; if (tap_b !== 32'h0 || vb !== 1'b0) $display("FAIL reset_b got %h/%b want 0/0", tap_b, vb); else n_pass++;
    release_rst();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 8'(i), 1'b0, 8'd0);
      n_checks++; if (tap_a !== ref_tap_a()) $display("FAIL fill_tap n=%0d got %h want %h", i, tap_a, ref_tap_a()); else n_pass++;
      n_checks++; if (va !== (i > 8)) $display("FAIL fill_valid n=%0d got %b want %b", i, va, i > 8); else n_pass++;
      n_checks++; if (col_a !== ref_col_a() || le_a !== (ref_col_a() == 2'd3)) $display("FAIL fill_col n=%0d got %0d/%b want %0d/%b", i, col_a, le_a, ref_col_a(), ref_col_a() == 2'd3); else n_pass++;
      if (i == 4) begin
        n_checks++; if (col_a !== 2'd3 || le_a !== 1'b1) $display("FAIL wrap_end got %0d/%b want 3/1", col_a, le_a); else n_pass++;
      end
      if (i == 5) begin
        n_checks++; if (col_a !== 2'd0 || le_a !== 1'b0) $display("FAIL wrap_start got %0d/%b want 0/0", col_a, le_a); else n_pass++;
      end
      if (i == 8) begin
        n_checks++; if (tap_a !== 24'h000408) $display("FAIL fill_8 got %h want 000408", tap_a); else n_pass++;
      end
    end
    n_checks++; if (tap_a !== 24'h010509 || va !== 1'b1) $display("FAIL fill_9 got %h/%b want 010509/1", tap_a, va); else n_pass++;
  endtask

  task automatic test_stall();
    step(1'b1, 8'd10, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 8'($urandom), 1'b0, 8'd0);
      n_checks++; if (tap_a !== 24'h02060a || va !== 1'b1 || col_a !== 2'd1 || le_a !== 1'b0) $display("FAIL stall_hold c=%0d got %h/%b/%0d/%b want 02060a/1/1/0", i, tap_a, va, col_a, le_a); else n_pass++;
    end
    step(1'b1, 8'd11, 1'b0, 8'd0);
    n_checks++; if (tap_a !== 24'h03070b) $display("FAIL stall_resume got %h want 03070b", tap_a); else n_pass++;
  endtask

  task automatic test_wrap();
    step(1'b1, 8'd12, 1'b0, 8'd0);
    step(1'b1, 8'd13, 1'b0, 8'd0);
    n_checks++; if (tap_a !== 24'h05090d || col_a !== 2'd0) $display("FAIL wrap_13 got %h/%0d want 05090d/0", tap_a, col_a); else n_pass++;
  endtask

  task automatic test_reset_mid();
    assert_rst();
    release_rst();
    for (int i = 1; i <= 12; i++) step(1'b1, 8'(i), 1'b0, 8'd0);
    n_checks++; if (tap_a !== 24'h04080c || va !== 1'b1) $display("FAIL mid_pre got %h/%b want 04080c/1", tap_a, va); else n_pass++;
    assert_rst();
    n_checks++; if (tap_a !== 24'h0 || va !== 1'b0 || col_a !== 2'd0 || le_a !== 1'b0) $display("FAIL mid_reset got %h/%b/%0d/%b want 0/0/0/0", tap_a, va, col_a, le_a); else n_pass++;
    release_rst();
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 8'(i), 1'b0, 8'd0);
      n_checks++; if (tap_a !== ref_tap_a() || va !== (i == 9)) $display("FAIL mid_refeed n=%0d got %h/%b want %h/%b", i, tap_a, va, ref_tap_a(), i == 9); else n_pass++;
    end
    n_checks++; if (tap_a !== 24'h010509) $display("FAIL mid_9 got %h want 010509", tap_a); else n_pass++;
  endtask

  task automatic test_random();
    assert_rst();
    release_rst();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        assert_rst();
        n_checks++; if (tap_b !== 32'h0 || vb !== 1'b0) $display("FAIL rand_reset got %h/%b want 0/0", tap_b, vb); else n_pass++;
        release_rst();
      end
      step(1'b0, 8'd0, $urandom_range(0, 9) < 7, 8'($urandom));
      n_checks++; if (tap_b !== ref_tap_b()) $display("FAIL rand_tap c=%0d got %h want %h", c, tap_b, ref_tap_b()); else n_pass++;
      n_checks++; if (vb !== (hb.size() > 15)) $display("FAIL rand_valid c=%0d got %b want %b", c, vb, hb.size() > 15); else n_pass++;
      n_checks++; if (col_b !== ref_col_b() || le_b !== (hb.size() != 0 && ref_col_b() == 3'd4)) $display("FAIL rand_col c=%0d got %0d/%b want %0d/%b", c, col_b, le_b, ref_col_b(), hb.size() != 0 && ref_col_b() == 3'd4); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sobel_line_buffer.md
SOBEL_LINE_BUFFER -- requirements
Module: sobel_line_buffer

Interface
REQ-001 Parameter DATA_W, default 8: pixel width in bits.
REQ-002 Parameter LINE_LEN, default 32: pixels per image line; legal range 2..1024.
REQ-003 Parameter NUM_LINES, default 2: number of cascaded line delays; legal range 1..4.
REQ-004 CLK  input  1: single clock; all state updates on the rising edge.
REQ-005 RST  input  1: reset; asynchronous, active-high.
REQ-006 Enable  input  1: sample strobe; a rising CLK edge with Enable=1 is one "enable cycle".
REQ-007 DataIn  input  DATA_W: pixel sampled on each enable cycle.
REQ-008 TapOut  output  (NUM_LINES+1)*DATA_W: flattened taps; slice k is bits [k*DATA_W +: DATA_W], k = 0..NUM_LINES.
REQ-009 Valid  output  1: all taps hold real data, i.e. a full vertical window is available.
REQ-010 Col  output  clog2(LINE_LEN): column index of the sample currently on slice 0.
REQ-011 LineEnd  output  1: high while Col = LINE_LEN-1 and at least one sample has been taken.

Function
REQ-012 Let n be the number of enable cycles since reset, and s_n the DataIn captured on enable cycle n (s_1 is the first).
REQ-013 After enable cycle n, slice k of TapOut shall equal s_(n-k*LINE_LEN) if n > k*LINE_LEN, else 0.
REQ-014 All outputs shall be registered; slice 0 shows s_n one CLK edge after s_n is presented, with zero extra latency.
REQ-015 Line k (1..NUM_LINES) shall be a circular buffer of LINE_LEN entries, with a shared write pointer that advances on each enable cycle and wraps from LINE_LEN-1 to 0.
REQ-016 Each enable cycle shall read the entry at the pointer before overwriting it (read-before-write). Line 1 writes DataIn; line k>1 writes the value read from line k-1.
REQ-017 Col shall equal (n-1) mod LINE_LEN for n >= 1.
REQ-018 Control FSM states:
  - FILL: after reset; a saturating fill counter increments per enable cycle.
  - RUN: entered on the enable cycle where n = NUM_LINES*LINE_LEN+1; held until reset.
REQ-019 Valid shall be 0 in FILL and 1 in RUN; it shall be registered and coincide with the TapOut update for that cycle.
REQ-020 With Enable=0, TapOut, Valid, Col, LineEnd, the pointer, the FSM and the storage shall all hold; idle gaps of any length are legal.
REQ-021 The fill counter shall saturate in RUN and never wrap; the pointer wrap shall not affect Valid.
REQ-022 LINE_LEN that is not a power of two shall wrap correctly, using an explicit compare, not modulo truncation.

Reset
REQ-023 RST=1 shall asynchronously force TapOut=0, Valid=0, Col=0, LineEnd=0, pointer=0, fill counter=0 and FSM=FILL.
REQ-024 Line storage shall not be reset; stale contents shall be masked by REQ-013 until overwritten.
REQ-025 RST asserted mid-operation shall restart the fill sequence; the first post-reset Valid shall occur on enable cycle NUM_LINES*LINE_LEN+1.
REQ-026 An enable cycle coincident with RST release-edge ambiguity is not required; the bench shall deassert RST away from CLK edges.

Structure
REQ-027 Shared package sobel_pkg shall hold the default DATA_W, the default LINE_LEN and the FSM state typedef (FILL, RUN).
REQ-028 Sub-module sobel_line_delay (one circular line, DATA_W x LINE_LEN, read-before-write, external pointer) shall be instantiated NUM_LINES times via generate.
REQ-029 The top level shall own the pointer, fill counter, FSM and output registers.

Verification (DATA_W=8, LINE_LEN=4, NUM_LINES=2; DataIn = n on enable cycle n)
REQ-030 Fill: enables 1..8 -> Valid=0 throughout; after enable 8, slices = {8,4,0}; after enable 9, slices = {9,5,1} and Valid=1.
REQ-031 Wrap: after enable 4 -> Col=3, LineEnd=1; after enable 5 -> Col=0, LineEnd=0; after enable 13 -> slices = {13,9,5}.
REQ-032 Stall: Enable=0 for 7 cycles after enable 10 -> all outputs hold {10,6,2}; the next enable gives {11,7,3}.
REQ-033 Reset mid-run: RST pulse after enable 12 -> outputs immediately 0 and Valid=0; re-feed 1..9 -> Valid first at the 9th enable with slices = {9,5,1}, with no stale data visible.
REQ-034 Random: continuous random DataIn with random Enable gaps (LINE_LEN=5, NUM_LINES=3) -> all taps match a reference queue model every cycle.
